// File: rtl/inst_fetch.sv
// Instruction-fetch front end: drives the instruction ROM with the fetch PC,
// captures each returned word into a small {pc, inst} prefetch FIFO, and hands
// the FIFO head to decode over a valid/ready handshake. Handles stall, branch
// redirect and flush (flush outranks branch).
module inst_fetch #(
  parameter int                 ADDR_W   = 64,
  parameter int                 INST_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count, count_next;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic              full, deq, fire;

  // Redirect targets are forced onto an 8-byte instruction boundary.
  function automatic logic [ADDR_W-1:0] align8(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign inst_valid_o = (count != '0);
  assign deq          = inst_valid_o & inst_ready_i;
  // A full FIFO may still accept a push when the head leaves on the same edge.
  assign fire         = rom_ce_o & ~stall_i & ~flush_i & ~branch_flag_i & (~full | deq);
  assign rom_addr_o   = pc;
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : '0;
  assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr]   : '0;

  // Fetch-enable state register: IDLE while in reset, FETCH afterwards.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and ROM enable decode.
  always_comb begin
    state_next = state;
    rom_ce_o   = 1'b0;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   rom_ce_o   = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after a simultaneous push/pop is unchanged.
  always_comb begin
    count_next = count;
    if (fire && !deq)      count_next = count + CNT_W'(1);
    else if (!fire && deq) count_next = count - CNT_W'(1);
  end

  // PC and FIFO control: flush beats branch beats normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      pc     <= align8(new_pc_i);
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (branch_flag_i) begin
      pc     <= align8(branch_target_i);
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (fire) begin
        pc     <= pc + ADDR_W'(8);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // FIFO payload storage; written at the tail on every fetch.
  always_ff @(posedge clk) begin
    if (fire) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= rom_inst_i;
    end
  end

endmodule
